delta_modulation: RTL and testbench



---
 rtl/delta_modulation.sv | 71 +++++++
 tb/tb_delta_modulation.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/delta_modulation.sv
// Single-channel delta-modulation spike encoder: emits ON/OFF pulses when the sample
// departs from a registered reference by at least a threshold. Optional macro DM_STEP_TRACK_EN.
module delta_modulation #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [W-1:0] data,
  input  logic [W-1:0] threshold,
  input  logic         off_spike_en,
  input  logic         load_prev,
  input  logic [W-1:0] force_prev,
  output logic [1:0]   spike,
  output logic [W-1:0] prev
);

  logic [W:0]   up_diff;
  logic [W:0]   dn_diff;
  logic         up_hit;
  logic         dn_hit;
  logic [W-1:0] up_next;
  logic [W-1:0] dn_next;

`ifdef DM_STEP_TRACK_EN
  logic [W-1:0] step;
  logic [W:0]   step_sum;
  logic [W:0]   step_dif;
`endif

  always_comb begin
    // Differences carry one extra bit so neither direction can wrap.
    up_diff = {1'b0, data} - {1'b0, prev};
    dn_diff = {1'b0, prev} - {1'b0, data};
    up_hit  = (data > prev) && (up_diff >= {1'b0, threshold});
    dn_hit  = (data < prev) && (dn_diff >= {1'b0, threshold});
`ifdef DM_STEP_TRACK_EN
    step     = (threshold == '0) ? {{(W-1){1'b0}}, 1'b1} : threshold;
    step_sum = {1'b0, prev} + {1'b0, step};
    step_dif = {1'b0, prev} - {1'b0, step};
    up_next  = step_sum[W] ? '1 : step_sum[W-1:0];
    dn_next  = step_dif[W] ? '0 : step_dif[W-1:0];
`else
    up_next  = data;
    dn_next  = data;
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      spike <= 2'b00;
      prev  <= '0;
    end else if (ena) begin
      if (load_prev) begin
        spike <= 2'b00;
        prev  <= force_prev;
      end else if (up_hit) begin
        spike <= 2'b01;
        prev  <= up_next;
      end else if (dn_hit) begin
        // The reference tracks downward even when the OFF pulse is masked.
        spike <= off_spike_en ? 2'b10 : 2'b00;
        prev  <= dn_next;
      end else begin
        spike <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_delta_modulation.sv
// Self-checking bench for delta_modulation: directed steps plus a short random run,
// expectations from an integer reference model queued at drive time and popped after the edge.
module tb_delta_modulation;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic [W-1:0] data;
  logic [W-1:0] threshold;
  logic         off_spike_en;
  logic         load_prev;
  logic [W-1:0] force_prev;
  logic [1:0]   spike;
  logic [W-1:0] prev;

  typedef struct {
    logic [1:0]   spike;
    logic [W-1:0] prev;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   m_prev      = 0;
  int   m_spike     = 0;

  delta_modulation #(.W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .data         (data),
    .threshold    (threshold),
    .off_spike_en (off_spike_en),
    .load_prev    (load_prev),
    .force_prev   (force_prev),
    .spike        (spike),
    .prev         (prev)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference model in plain integer arithmetic.
  task automatic model(input bit r, input bit e, input int d, input int th,
                       input bit off, input bit lp, input int fp);
    int diff;
    int st;
    diff = d - m_prev;
    st   = (th == 0) ? 1 : th;
    if (r) begin
      m_prev  = 0;
      m_spike = 0;
    end else if (e) begin
      if (lp) begin
        m_prev  = fp;
        m_spike = 0;
      end else if (diff > 0 && diff >= th) begin
        m_spike = 1;
`ifdef DM_STEP_TRACK_EN
        m_prev  = (m_prev + st > MAXV) ? MAXV : m_prev + st;
`else
        m_prev  = d;
`endif
      end else if (diff < 0 && -diff >= th) begin
        m_spike = off ? 2 : 0;
`ifdef DM_STEP_TRACK_EN
        m_prev  = (m_prev - st < 0) ? 0 : m_prev - st;
`else
        m_prev  = d;
`endif
      end else begin
        m_spike = 0;
      end
    end
  endtask

  task automatic apply(input string tag, input bit r, input bit e, input int d,
                       input int th, input bit off, input bit lp, input int fp);
    exp_t x;
    exp_t got;
    rst          = r;
    ena          = e;
    data         = d[W-1:0];
    threshold    = th[W-1:0];
    off_spike_en = off;
    load_prev    = lp;
    force_prev   = fp[W-1:0];
    model(r, e, d, th, off, lp, fp);
    x.spike = m_spike[1:0];
    x.prev  = m_prev[W-1:0];
    x.tag   = tag;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check({got.tag, ".spike"}, int'(spike), int'(got.spike));
    check({got.tag, ".prev"},  int'(prev),  int'(got.prev));
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; data = '0; threshold = '0;
    off_spike_en = 1'b0; load_prev = 1'b0; force_prev = '0;

    // Reset wins over load and enable.
    apply("rst0",        1, 1, 7,  2, 1, 1, 9);
    apply("rst1",        1, 1, 13, 0, 0, 0, 3);
    apply("ena_off",     0, 0, 9,  1, 1, 0, 0);

    // Up spike, pulse return, sub-threshold move.
    apply("up",          0, 1, 5,  3, 1, 0, 0);
    apply("up_hold",     0, 1, 5,  3, 1, 0, 0);
    apply("up_small",    0, 1, 7,  3, 1, 0, 0);

    // Down spike, then masked OFF still tracks.
    apply("load5",       0, 1, 0,  3, 1, 1, 5);
    apply("down",        0, 1, 2,  3, 1, 0, 0);
    apply("load10",      0, 1, 2,  3, 0, 1, 10);
    apply("down_mask",   0, 1, 2,  3, 0, 0, 0);

    // Load priority, hold under ena=0, reset clears.
    apply("load12",      0, 1, 0,  1, 1, 1, 12);
    apply("load_noena",  0, 0, 0,  1, 1, 1, 3);
    apply("load_rst",    1, 1, 0,  1, 1, 1, 12);

    // Range boundaries.
    apply("load15",      0, 1, 0,  0, 1, 1, 15);
    apply("eq_th0",      0, 1, 15, 0, 1, 0, 0);
    apply("down_full",   0, 1, 0,  15, 1, 0, 0);
    apply("up_full",     0, 1, 15, 15, 1, 0, 0);
    apply("th0_down",    0, 1, 14, 0, 1, 0, 0);
    apply("th0_up",      0, 1, 15, 0, 1, 0, 0);
    apply("spike_hold",  0, 0, 0,  0, 1, 0, 0);
    apply("spike_clear", 0, 1, 15, 15, 1, 0, 0);

`ifdef DM_STEP_TRACK_EN
    apply("st_load0",    0, 1, 0,  3, 1, 1, 0);
    for (int i = 0; i < 4; i++) apply($sformatf("st_ramp%0d", i), 0, 1, 10, 3, 1, 0, 0);
    apply("st_load14",   0, 1, 0,  5, 1, 1, 14);
    apply("st_small",    0, 1, 15, 5, 1, 0, 0);
    apply("st_th0",      0, 1, 15, 0, 1, 0, 0);
    apply("st_load2",    0, 1, 0,  4, 0, 1, 2);
    apply("st_floor",    0, 1, 0,  2, 0, 0, 0);
`endif

    // Random mix against the model.
    for (int i = 0; i < 40; i++) begin
      apply($sformatf("rnd%0d", i),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 5) != 0),
            $urandom_range(0, MAXV), $urandom_range(0, 6), $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0), $urandom_range(0, MAXV));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
